// File: rtl/marc_ctrl_pkg.sv
// ------------------------------------------------------------------
// | marc_ctrl_pkg: state indices, one-hot state type, opcode codes |
// | Rev 1.0                                                        |
// ------------------------------------------------------------------
`default_nettype none

package marc_ctrl_pkg;

  localparam int NSTATES = 14;

  localparam int S_FETCH     = 0;
  localparam int S_DECODE    = 1;
  localparam int S_OPF_ALU   = 2;
  localparam int S_EXE_ALU   = 3;
  localparam int S_OPF_MEM   = 4;
  localparam int S_EXE_MEM   = 5;
  localparam int S_OPF_JMP   = 6;
  localparam int S_EXE_JMP   = 7;
  localparam int S_OPF_SET   = 8;
  localparam int S_EXE_SET   = 9;
  localparam int S_LINK      = 10;
  localparam int S_LINK_CALL = 11;
  localparam int S_UPD_PC    = 12;
  localparam int S_ERR       = 13;

  localparam logic [3:0] OPC_MUL   = 4'b1000;
  localparam logic [3:0] OPC_JMP   = 4'b1001;
  localparam logic [2:0] OPC_MEM_M = 3'b011;
  localparam logic [2:0] OPC_SET_M = 3'b101;

  typedef enum logic [NSTATES-1:0] {
    ST_FETCH     = NSTATES'(1) << S_FETCH,
    ST_DECODE    = NSTATES'(1) << S_DECODE,
    ST_OPF_ALU   = NSTATES'(1) << S_OPF_ALU,
    ST_EXE_ALU   = NSTATES'(1) << S_EXE_ALU,
    ST_OPF_MEM   = NSTATES'(1) << S_OPF_MEM,
    ST_EXE_MEM   = NSTATES'(1) << S_EXE_MEM,
    ST_OPF_JMP   = NSTATES'(1) << S_OPF_JMP,
    ST_EXE_JMP   = NSTATES'(1) << S_EXE_JMP,
    ST_OPF_SET   = NSTATES'(1) << S_OPF_SET,
    ST_EXE_SET   = NSTATES'(1) << S_EXE_SET,
    ST_LINK      = NSTATES'(1) << S_LINK,
    ST_LINK_CALL = NSTATES'(1) << S_LINK_CALL,
    ST_UPD_PC    = NSTATES'(1) << S_UPD_PC,
    ST_ERR       = NSTATES'(1) << S_ERR
  } state_t;

  // Call format wins over the function code; every code maps somewhere.
  function automatic state_t decode_next(input logic opc1, input logic [3:0] opc2);
    state_t nxt;
    if (opc1)                       nxt = ST_LINK;
    else if (opc2[3:1] == OPC_MEM_M) nxt = ST_OPF_MEM;
    else if (opc2 == OPC_JMP)        nxt = ST_OPF_JMP;
    else if (opc2[3:1] == OPC_SET_M) nxt = ST_OPF_SET;
    else                             nxt = ST_OPF_ALU;
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_wait_counter.sv
// ------------------------------------------------------------------
// | ctrl_wait_counter: clearable wait counter with terminal compare |
// | Rev 1.0                                                         |
// ------------------------------------------------------------------
`default_nettype none

module ctrl_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             hold,
  input  logic [CNT_W-1:0] term,
  output logic             at_term
);

  logic [CNT_W-1:0] r_cnt;

  // hold has priority so a stalled wait keeps its elapsed count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!hold) begin
      if (clr)     r_cnt <= '0;
      else if (en) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_term = (r_cnt == term);

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ------------------------------------------------------------------
// | control_sequencer: one-hot mARC main sequencer with mem wait,   |
// | stall, multi-cycle multiply and sticky bus-error state          |
// | Rev 1.0                                                         |
// ------------------------------------------------------------------
`default_nettype none

module control_sequencer
  import marc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int MUL_LAT     = 4,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               opc1,
  input  logic [3:0]         opc2,
  input  logic               stall,
  input  logic               mem_ready,
  output logic [NSTATES-1:0] state,
  output logic               err,
  output logic               retire
);

  localparam logic [CNT_W-1:0] c_tmo_term = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_mul_term = CNT_W'(MUL_LAT - 1);

  state_t           r_state;
  logic             r_opc1;
  logic [3:0]       r_opc2;
  logic             r_err;

  logic             w_tmo_en;
  logic             w_mem_wait;
  logic             w_mul;
  logic             w_at_term;
  logic             w_tmo;
  logic             w_wait;
  logic [CNT_W-1:0] w_term;

  if (MEM_TIMEOUT == 0) begin : g_tmo_off
    assign w_tmo_en = 1'b0;
  end else begin : g_tmo_on
    assign w_tmo_en = 1'b1;
  end

  assign w_mem_wait = (r_state == ST_FETCH) || (r_state == ST_EXE_MEM);
  assign w_mul      = (r_state == ST_EXE_ALU) && !r_opc1 && (r_opc2 == OPC_MUL);
  assign w_term     = w_mul ? c_mul_term : c_tmo_term;
  assign w_tmo      = w_tmo_en && w_mem_wait && w_at_term;

  // Counter advances only while the FSM stays put; any exit clears it.
  assign w_wait = (w_mem_wait && !mem_ready && !w_tmo) || (w_mul && !w_at_term);

  ctrl_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!w_wait),
    .en      (w_wait),
    .hold    (stall),
    .term    (w_term),
    .at_term (w_at_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_opc1  <= 1'b0;
      r_opc2  <= 4'b0000;
      r_err   <= 1'b0;
    end else if (!stall) begin
      case (r_state)
        ST_FETCH: begin
          if (mem_ready) begin
            r_state <= ST_DECODE;
          end else if (w_tmo) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end
        end
        ST_DECODE: begin
          r_opc1  <= opc1;
          r_opc2  <= opc2;
          r_state <= decode_next(opc1, opc2);
        end
        ST_OPF_ALU:   r_state <= ST_EXE_ALU;
        ST_EXE_ALU: begin
          if (!w_mul || w_at_term) r_state <= ST_UPD_PC;
        end
        ST_OPF_MEM:   r_state <= ST_EXE_MEM;
        ST_EXE_MEM: begin
          if (mem_ready) begin
            r_state <= ST_UPD_PC;
          end else if (w_tmo) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end
        end
        ST_OPF_JMP:   r_state <= ST_EXE_JMP;
        ST_EXE_JMP:   r_state <= ST_UPD_PC;
        ST_OPF_SET:   r_state <= ST_EXE_SET;
        ST_EXE_SET:   r_state <= ST_UPD_PC;
        ST_LINK:      r_state <= ST_LINK_CALL;
        ST_LINK_CALL: r_state <= ST_UPD_PC;
        ST_UPD_PC:    r_state <= ST_FETCH;
        ST_ERR:       r_state <= ST_ERR;
        default:      r_state <= ST_FETCH;
      endcase
    end
  end

  assign state  = r_state;
  assign err    = r_err;
  assign retire = state[S_UPD_PC] & ~stall;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ------------------------------------------------------------------
// | tb_control_sequencer: directed + random check of the sequencer  |
// | Rev 1.0                                                         |
// ------------------------------------------------------------------
`default_nettype none

module tb_control_sequencer;

  localparam int MT = 15;
  localparam int ML = 4;

  localparam int I_FETCH = 0,  I_DEC = 1,  I_OPF_ALU = 2, I_EXE_ALU = 3;
  localparam int I_OPF_MEM = 4, I_EXE_MEM = 5, I_OPF_JMP = 6, I_EXE_JMP = 7;
  localparam int I_OPF_SET = 8, I_EXE_SET = 9, I_LINK = 10, I_LINK_CALL = 11;
  localparam int I_UPD = 12, I_ERR = 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        opc1 = 1'b0;
  logic [3:0]  opc2 = 4'd0;
  logic        stall = 1'b0;
  logic        mem_ready = 1'b0;
  logic [13:0] state;
  logic        err;
  logic        retire;

  int n_chk = 0;
  int n_pass = 0;

  // reference model: current state index, cycles already waited, latched code
  int m_st, m_wait, m_opc2, m_opc1, m_err;

  int exp1[6] = '{0, 1, 2, 3, 12, 0};

  control_sequencer #(
    .MEM_TIMEOUT (MT),
    .MUL_LAT     (ML),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opc1      (opc1),
    .opc2      (opc2),
    .stall     (stall),
    .mem_ready (mem_ready),
    .state     (state),
    .err       (err),
    .retire    (retire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int opf_of(input int o);
    if (o / 2 == 3)      return I_OPF_MEM;
    else if (o == 9)     return I_OPF_JMP;
    else if (o / 2 == 5) return I_OPF_SET;
    else                 return I_OPF_ALU;
  endfunction

  task automatic model_reset();
    m_st = I_FETCH; m_wait = 0; m_opc1 = 0; m_opc2 = 0; m_err = 0;
  endtask

  task automatic go(input int s);
    m_st = s; m_wait = 0;
  endtask

  task automatic model_step();
    if (m_st == I_ERR || stall) return;
    case (m_st)
      I_FETCH, I_EXE_MEM: begin
        if (mem_ready) go(m_st == I_FETCH ? I_DEC : I_UPD);
        else if (MT != 0 && m_wait == MT - 1) begin go(I_ERR); m_err = 1; end
        else m_wait++;
      end
      I_DEC: begin
        m_opc1 = int'(opc1); m_opc2 = int'(opc2);
        go(opc1 ? I_LINK : opf_of(int'(opc2)));
      end
      I_EXE_ALU: begin
        if (m_opc2 == 8 && m_wait < ML - 1) m_wait++;
        else go(I_UPD);
      end
      I_OPF_ALU, I_OPF_MEM, I_OPF_JMP, I_OPF_SET, I_LINK: go(m_st + 1);
      I_EXE_JMP, I_EXE_SET, I_LINK_CALL: go(I_UPD);
      I_UPD: go(I_FETCH);
      default: go(I_FETCH);
    endcase
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(1) << m_st);
    chk("err", 32'(err), 32'(m_err));
    chk("retire", 32'(retire), 32'(m_st == I_UPD && !stall));
    chk("onehot", 32'($onehot(state)), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  // reset asserted away from any clock edge, released on a falling edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_state", 32'(state), 32'd1);
    chk("rst_async_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    int cyc, cnt_a, cnt_b, aux;
    bit lowmr;

    model_reset();
    @(negedge clk);

    // 1) plain ALU instruction, zero-wait memory
    opc1 = 0; opc2 = 4'b0101; mem_ready = 1; stall = 0;
    do_reset();
    chk("t1_s0", 32'(state), 32'(1) << exp1[0]);
    for (int k = 1; k < 6; k++) begin
      tick();
      chk($sformatf("t1_s%0d", k), 32'(state), 32'(1) << exp1[k]);
      if (k == 4) chk("t1_retire", 32'(retire), 32'd1);
    end

    // 2) multiply holds EXE_ALU for MUL_LAT cycles
    opc2 = 4'b1000;
    cyc = 0; cnt_a = 0; cnt_b = 0;
    do begin
      tick(); cyc++;
      if (state[I_EXE_ALU]) cnt_a++;
      if (retire) cnt_b++;
    end while (!state[I_FETCH] && cyc < 30);
    chk("t2_cycles", 32'(cyc), 32'd8);
    chk("t2_exe_alu", 32'(cnt_a), 32'd4);
    chk("t2_retires", 32'(cnt_b), 32'd1);

    // 3) memory op with three wait cycles
    opc2 = 4'b0110;
    cyc = 0; cnt_a = 0; aux = 0;
    do begin
      if (state[I_EXE_MEM] && aux < 3) begin mem_ready = 0; aux++; end
      else mem_ready = 1;
      tick(); cyc++;
      if (state[I_EXE_MEM]) cnt_a++;
    end while (!state[I_FETCH] && cyc < 40);
    chk("t3_cycles", 32'(cyc), 32'd8);
    chk("t3_exe_mem", 32'(cnt_a), 32'd4);
    chk("t3_err", 32'(err), 32'd0);

    // 4) fetch timeout into sticky ERR
    mem_ready = 0;
    do_reset();
    cnt_a = 1; cyc = 0;
    do begin
      tick(); cyc++;
      if (state[I_FETCH]) cnt_a++;
    end while (!state[I_ERR] && cyc < 40);
    chk("t4_fetch_cycles", 32'(cnt_a), 32'd15);
    chk("t4_err", 32'(err), 32'd1);
    mem_ready = 1;
    for (int k = 0; k < 5; k++) begin
      stall = 1'($urandom_range(0, 1));
      tick();
    end
    stall = 0;
    chk("t4_err_sticky", 32'(err), 32'd1);
    chk("t4_state_err", 32'(state), 32'(1) << I_ERR);
    do_reset();
    chk("t4_err_cleared", 32'(err), 32'd0);

    // 5) call format bypasses memory; stall freezes LINK_CALL
    opc1 = 1; opc2 = 4'b0110; mem_ready = 1;
    cyc = 0; cnt_a = 0; cnt_b = 0; aux = 0;
    do begin
      if (state[I_LINK_CALL] && aux < 3) begin stall = 1; aux++; end
      else stall = 0;
      tick(); cyc++;
      if (state[I_OPF_MEM] || state[I_EXE_MEM]) cnt_b++;
      if (state[I_LINK_CALL]) cnt_a++;
    end while (!state[I_FETCH] && cyc < 30);
    stall = 0;
    chk("t5_cycles", 32'(cyc), 32'd8);
    chk("t5_link_call", 32'(cnt_a), 32'd4);
    chk("t5_no_mem", 32'(cnt_b), 32'd0);

    // 6) decode of all 16 function codes
    opc1 = 0; mem_ready = 1;
    for (int i = 0; i < 16; i++) begin
      opc2 = 4'(i);
      tick();
      tick();
      chk($sformatf("t6_dec_%0d", i), 32'(state), 32'(1) << opf_of(i));
      cyc = 0;
      do begin tick(); cyc++; end while (!state[I_FETCH] && cyc < 20);
      chk($sformatf("t6_back_%0d", i), 32'(state), 32'd1);
    end

    // async reset in the middle of an EXE_MEM wait
    opc2 = 4'b0111;
    tick(); tick(); tick();
    mem_ready = 0;
    tick(); tick();
    chk("t6_in_exe_mem", 32'(state), 32'(1) << I_EXE_MEM);
    #2;
    do_reset();

    // random phase against the model
    aux = 0; lowmr = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 100 == 0) lowmr = ($urandom_range(0, 2) == 0);
      opc1 = ($urandom_range(0, 3) == 0);
      opc2 = 4'($urandom_range(0, 15));
      stall = ($urandom_range(0, 4) == 0);
      mem_ready = lowmr ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) < 6);
      if (m_st == I_ERR) aux++;
      if (aux > 4 || $urandom_range(0, 499) == 0) begin
        aux = 0;
        do_reset();
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
